// File: rtl/tick_counter.sv
// tick_counter: synchronous up/down counter with parallel load, driven by a
// synchronised, edge-detected count request rather than a derived clock.
//
// Ports:
//   clk      board clock, all state changes on its rising edge
//   rst      synchronous active-high reset
//   tick_in  asynchronous count request, one step per rising edge
//   en       count enable, steps are discarded while low
//   up       direction, 1 = increment, 0 = decrement
//   load     synchronous parallel load, active-high
//   d        load value, clamped to MAX_COUNT
//   q        current count
//   tc       terminal-count pulse, one cycle after a boundary step
//   ovf      sticky overflow/underflow flag, cleared by rst or load
module tick_counter #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned MAX_COUNT   = 9,
    parameter int unsigned SATURATE    = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ZERO_Q = '0;
    localparam logic [WIDTH-1:0] ONE_Q  = WIDTH'(1);
    localparam bit               SAT    = (SATURATE != 0);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev;
    logic                   s_last;
    logic                   step;

    logic [WIDTH-1:0]       q_next;
    logic                   tc_next;
    logic                   ovf_next;

    // Synchroniser chain and edge-detect flop; reset to ones so a level that
    // is already high when reset releases is not seen as a new edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            prev   <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
            prev   <= s_last;
        end
    end

    assign s_last = sync_q[SYNC_STAGES-1];
    assign step   = s_last & ~prev;

    // Next-state logic: load beats a counting step, which beats hold.
    always_comb begin
        q_next   = q;
        tc_next  = 1'b0;
        ovf_next = ovf;
        if (load) begin
            q_next   = (d > MAX_Q) ? MAX_Q : d;
            ovf_next = 1'b0;
        end else if (step && en) begin
            if (up) begin
                if (q >= MAX_Q) begin
                    q_next   = SAT ? MAX_Q : ZERO_Q;
                    tc_next  = 1'b1;
                    ovf_next = 1'b1;
                end else begin
                    q_next = q + ONE_Q;
                end
            end else begin
                if (q == ZERO_Q) begin
                    q_next   = SAT ? ZERO_Q : MAX_Q;
                    tc_next  = 1'b1;
                    ovf_next = 1'b1;
                end else begin
                    q_next = q - ONE_Q;
                end
            end
        end
    end

    // Count, terminal-count and overflow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            q   <= q_next;
            tc  <= tc_next;
            ovf <= ovf_next;
        end
    end

endmodule
